cms_io_sequencer: RTL and testbench

Host-side write sequencer for the Creative Music System / Game Blaster sound card: decodes the 16-byte CMS I/O window, queues register writes for the two `saa1099` instances, and replays them as clean `cs_n`/`wr_n` pulses on the chip bus. It also provides the CMS detection latches and ID byte so software probing succeeds. It sits between the ISA I/O decode and the two `saa1099` instances (left/right chip pair).

---
 rtl/cms_io_sequencer.sv | 265 ++++++++++++++++++++++++++
 tb/tb_cms_io_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cms_io_sequencer.sv
// cms_io_sequencer
// Host-side write sequencer for the CMS / Game Blaster card. Decodes the
// 16-byte I/O window, queues register writes for the two SAA1099 chips and
// replays them as cs_n/wr_n pulses on the shared chip bus.
// Optional feature macro: CMS_DETECT_EN builds the detection latches
// (offsets 6/7 write, 0xA/0xB read back) and the ID byte at offset 4.
// Without it every read returns 8'hFF and writes to 6/7 are ignored.

module cms_io_sequencer #(
   parameter int FIFO_DEPTH = 8,
   parameter int SETUP_CYC  = 1,
   parameter int LOW_CYC    = 2,
   parameter int GAP_CYC    = 2
) (
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic       io_cs,
   input  logic [3:0] io_addr,
   input  logic       io_wr,
   input  logic       io_rd,
   input  logic [7:0] io_din,
   output logic [7:0] io_dout,
   output logic       io_ready,
   output logic       ovf,
   output logic [1:0] saa_cs_n,
   output logic       saa_a0,
   output logic       saa_wr_n,
   output logic [7:0] saa_din
);

   localparam int AW      = $clog2(FIFO_DEPTH);
   localparam int MAX_CYC = (SETUP_CYC > LOW_CYC)
                            ? ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC)
                            : ((LOW_CYC > GAP_CYC) ? LOW_CYC : GAP_CYC);
   localparam int CW      = $clog2(MAX_CYC) + 1;

   localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] LOW_LD   = CW'(LOW_CYC - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_LOW,
      ST_GAP
   } state_t;

   typedef struct packed {
      logic       chip;
      logic       a0;
      logic [7:0] data;
   } entry_t;

   // ------------------------------------------------------------------
   // Host-side decode
   // ------------------------------------------------------------------
   logic wr_en;
   logic rd_en;
   logic push_req;

   // A write strobe wins over a simultaneous read strobe.
   assign wr_en    = io_cs & io_wr;
   assign rd_en    = io_cs & io_rd & ~io_wr;
   // Offsets 0..3 are the chip data/address ports and go through the queue.
   assign push_req = wr_en & (io_addr[3:2] == 2'b00);

   // ------------------------------------------------------------------
   // Write queue
   // ------------------------------------------------------------------
   entry_t        mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_nxt;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   entry_t        head;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   // Fullness is judged at the start of the cycle; a same-cycle pop does
   // not make room for the push.
   assign push  = push_req & ~full;
   assign head  = mem[rd_ptr];

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + 1'b1;
      end else if (!push && pop) begin
         count_nxt = count - 1'b1;
      end
   end

   // Queue storage.
   // NOTE: storage has no reset; entries are only read once count says valid.
   always_ff @(posedge clk_sys) begin
      if (push) begin
         mem[wr_ptr] <= '{chip: io_addr[1], a0: io_addr[0], data: io_din};
      end
   end

   // Queue pointers, occupancy, ready and sticky overflow.
   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         io_ready <= 1'b1;
         ovf      <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count    <= count_nxt;
         io_ready <= (count_nxt != FULL_CNT);
         if (push_req && full) begin
            ovf <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Chip-bus sequencer
   // ------------------------------------------------------------------
   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [1:0]    cs_n_nxt;
   logic          wr_n_nxt;
   logic          a0_nxt;
   logic [7:0]    din_nxt;

   // State, phase counter and registered chip-bus outputs.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         saa_cs_n <= 2'b11;
         saa_wr_n <= 1'b1;
         saa_a0   <= 1'b0;
         saa_din  <= 8'h00;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         saa_cs_n <= cs_n_nxt;
         saa_wr_n <= wr_n_nxt;
         saa_a0   <= a0_nxt;
         saa_din  <= din_nxt;
      end
   end

   // Next state, counter reload and next chip-bus values.
   // NOTE: every output gets a hold default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cs_n_nxt  = saa_cs_n;
      wr_n_nxt  = saa_wr_n;
      a0_nxt    = saa_a0;
      din_nxt   = saa_din;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               din_nxt   = head.data;
               a0_nxt    = head.a0;
               cs_n_nxt  = head.chip ? 2'b01 : 2'b10;
               cnt_nxt   = SETUP_LD;
               state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt == '0) begin
               wr_n_nxt  = 1'b0;
               cnt_nxt   = LOW_LD;
               state_nxt = ST_LOW;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_LOW: begin
            if (cnt == '0) begin
               // Data and a0 stay put through GAP for the chip's late sample.
               wr_n_nxt  = 1'b1;
               cs_n_nxt  = 2'b11;
               cnt_nxt   = GAP_LD;
               state_nxt = ST_GAP;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt == '0) begin
               state_nxt = ST_IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Detection latches and readback
   // ------------------------------------------------------------------
   logic [7:0] rd_data;

`ifdef CMS_DETECT_EN
   logic [7:0] det0;
   logic [7:0] det1;

   // Detection latches written directly, bypassing the queue.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         det0 <= 8'h00;
         det1 <= 8'h00;
      end else if (wr_en) begin
         if (io_addr == 4'h6) begin
            det0 <= io_din;
         end
         if (io_addr == 4'h7) begin
            det1 <= io_din;
         end
      end
   end

   // Read mux: ID byte and the two detection latches.
   always_comb begin
      rd_data = 8'hFF;
      case (io_addr)
         4'h4:    rd_data = 8'h7F;
         4'hA:    rd_data = det0;
         4'hB:    rd_data = det1;
         default: rd_data = 8'hFF;
      endcase
   end
`else
   // Card looks absent to probes.
   assign rd_data = 8'hFF;
`endif

   // Registered read data, held until the next read.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         io_dout <= 8'h00;
      end else if (rd_en) begin
         io_dout <= rd_data;
      end
   end

endmodule

// File: tb/tb_cms_io_sequencer.sv
// Bench for cms_io_sequencer: a phase-timeline model of the chip bus plus
// a queue model of the FIFO, compared every cycle, and literal checks on
// the captured write-pulse log. Follows CMS_DETECT_EN if defined.

module tb_cms_io_sequencer;

   localparam int S     = 1;
   localparam int L     = 2;
   localparam int G     = 2;
   localparam int DEPTH = 8;

   logic       clk_sys = 1'b0;
   logic       rst_n   = 1'b1;
   logic       io_cs   = 1'b0;
   logic [3:0] io_addr = 4'h0;
   logic       io_wr   = 1'b0;
   logic       io_rd   = 1'b0;
   logic [7:0] io_din  = 8'h00;
   logic [7:0] io_dout;
   logic       io_ready;
   logic       ovf;
   logic [1:0] saa_cs_n;
   logic       saa_a0;
   logic       saa_wr_n;
   logic [7:0] saa_din;

   cms_io_sequencer #(
      .FIFO_DEPTH (DEPTH),
      .SETUP_CYC  (S),
      .LOW_CYC    (L),
      .GAP_CYC    (G)
   ) dut (
      .clk_sys  (clk_sys),
      .rst_n    (rst_n),
      .io_cs    (io_cs),
      .io_addr  (io_addr),
      .io_wr    (io_wr),
      .io_rd    (io_rd),
      .io_din   (io_din),
      .io_dout  (io_dout),
      .io_ready (io_ready),
      .ovf      (ovf),
      .saa_cs_n (saa_cs_n),
      .saa_a0   (saa_a0),
      .saa_wr_n (saa_wr_n),
      .saa_din  (saa_din)
   );

   always #5 clk_sys = ~clk_sys;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   logic [9:0] mq[$];
   int         phase;
   logic [9:0] cur;
   logic       m_ovf;
   logic       m_ready;
   logic [7:0] m_dout;
   logic [7:0] m_det0;
   logic [7:0] m_det1;

   task automatic model_reset();
      mq.delete();
      phase   = -1;
      cur     = '0;
      m_ovf   = 1'b0;
      m_ready = 1'b1;
      m_dout  = 8'h00;
      m_det0  = 8'h00;
      m_det1  = 8'h00;
   endtask

   function automatic logic [7:0] read_value(input logic [3:0] a);
`ifdef CMS_DETECT_EN
      if (a == 4'h4) return 8'h7F;
      if (a == 4'hA) return m_det0;
      if (a == 4'hB) return m_det1;
      return 8'hFF;
`else
      return 8'hFF;
`endif
   endfunction

   task automatic model_step();
      int   sz;
      logic wr;
      logic rd;
      sz = mq.size();
      wr = io_cs && io_wr;
      rd = io_cs && io_rd && !io_wr;
      if (rd) m_dout = read_value(io_addr);
      // Sequencer timeline: one pulse occupies S+L+G cycles after its pop.
      if (phase < 0 && sz > 0) begin
         cur   = mq.pop_front();
         phase = 0;
      end else if (phase >= 0) begin
         phase = (phase == S + L + G - 1) ? -1 : phase + 1;
      end
      if (wr && io_addr < 4) begin
         if (sz < DEPTH) mq.push_back({io_addr[1], io_addr[0], io_din});
         else            m_ovf = 1'b1;
      end
`ifdef CMS_DETECT_EN
      if (wr && io_addr == 4'h6) m_det0 = io_din;
      if (wr && io_addr == 4'h7) m_det1 = io_din;
`endif
      m_ready = (mq.size() < DEPTH);
   endtask

   task automatic compare();
      logic [1:0] exp_cs;
      logic       exp_wr;
      exp_cs = (phase >= 0 && phase < S + L) ? (cur[9] ? 2'b01 : 2'b10) : 2'b11;
      exp_wr = (phase >= S && phase < S + L) ? 1'b0 : 1'b1;
      check("cs_n",  saa_cs_n, exp_cs);
      check("wr_n",  saa_wr_n, exp_wr);
      check("a0",    saa_a0,   cur[8]);
      check("din",   saa_din,  cur[7:0]);
      check("ready", io_ready, m_ready);
      check("ovf",   ovf,      m_ovf);
      check("dout",  io_dout,  m_dout);
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk_sys);
         if (!rst_n) model_reset();
         else        model_step();
         @(negedge clk_sys);
         if (!rst_n) model_reset();
         compare();
      end
   end

   // ---------------- pulse log ----------------
   logic [1:0] p_cs  [64];
   logic       p_a0  [64];
   logic [7:0] p_din [64];
   int         p_cyc [64];
   int         np = 0;

   initial begin
      logic prev_wr;
      prev_wr = 1'b1;
      forever begin
         @(negedge clk_sys);
         if (prev_wr && !saa_wr_n && np < 64) begin
            p_cs[np]  = saa_cs_n;
            p_a0[np]  = saa_a0;
            p_din[np] = saa_din;
            p_cyc[np] = cyc;
            np++;
         end
         prev_wr = saa_wr_n;
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic drive_wr(input logic [3:0] a, input logic [7:0] d);
      io_cs = 1'b1; io_wr = 1'b1; io_addr = a; io_din = d;
      @(posedge clk_sys); #1;
      io_cs = 1'b0; io_wr = 1'b0;
   endtask

   task automatic drive_rd(input logic [3:0] a);
      io_cs = 1'b1; io_rd = 1'b1; io_addr = a;
      @(posedge clk_sys); #1;
      io_cs = 1'b0; io_rd = 1'b0;
   endtask

   task automatic check_pulse(input int i, input logic [1:0] cs, input logic a0, input logic [7:0] d);
      check($sformatf("pulse%0d_cs", i),  p_cs[i],  cs);
      check($sformatf("pulse%0d_a0", i),  p_a0[i],  a0);
      check($sformatf("pulse%0d_din", i), p_din[i], d);
   endtask

   logic [7:0] exp_id;
   logic [7:0] exp_det1;
   logic [7:0] exp_det0;
   int         t_wr;
   logic       found;

   initial begin
`ifdef CMS_DETECT_EN
      exp_id = 8'h7F; exp_det1 = 8'hA5; exp_det0 = 8'h00;
`else
      exp_id = 8'hFF; exp_det1 = 8'hFF; exp_det0 = 8'hFF;
`endif
      #2 rst_n = 1'b0;
      idle(3);
      check("rst_cs_n",  saa_cs_n, 2'b11);
      check("rst_wr_n",  saa_wr_n, 1'b1);
      check("rst_ready", io_ready, 1'b1);
      check("rst_dout",  io_dout,  8'h00);
      rst_n = 1'b1;
      idle(2);

      // Two writes to chip 0: address then data.
      drive_wr(4'h1, 8'h1C);
      t_wr = cyc;
      drive_wr(4'h0, 8'h02);
      idle(20);
      check("t1_count", np, 2);
      check_pulse(0, 2'b10, 1'b1, 8'h1C);
      check_pulse(1, 2'b10, 1'b0, 8'h02);
      check("t1_latency", p_cyc[0] - t_wr, 1 + S);
      check("t1_spacing", p_cyc[1] - p_cyc[0], 6);

      // Detection latch and ID readback; ignored writes and both-strobe case.
      drive_wr(4'h7, 8'hA5);
      drive_rd(4'hB);
      check("rd_det1", io_dout, exp_det1);
      drive_rd(4'h4);
      check("rd_id", io_dout, exp_id);
      drive_rd(4'hA);
      check("rd_det0", io_dout, exp_det0);
      io_cs = 1'b1; io_wr = 1'b1; io_rd = 1'b1; io_addr = 4'h4; io_din = 8'h99;
      @(posedge clk_sys); #1;
      io_cs = 1'b0; io_wr = 1'b0; io_rd = 1'b0;
      check("rd_wr_wins", io_dout, exp_det0);
      drive_wr(4'h5, 8'h33);
      io_wr = 1'b1; io_addr = 4'h0; io_din = 8'h44;
      @(posedge clk_sys); #1;
      io_wr = 1'b0;
      idle(10);
      check("t2_count", np, 2);

      // Back-to-back burst to chip 1 data, overflowing the queue.
      for (int i = 0; i < 12; i++) begin
         drive_wr(4'h2, 8'h40 + 8'(i));
         if (i == 8) check("burst_ready_7", io_ready, 1'b1);
         if (i == 9) begin
            check("burst_ready_full", io_ready, 1'b0);
            check("burst_ovf_before", ovf, 1'b0);
         end
      end
      check("burst_ovf", ovf, 1'b1);
      idle(90);
      check("t3_count", np, 12);
      for (int k = 0; k < 10; k++) check_pulse(2 + k, 2'b01, 1'b0, 8'h40 + 8'(k));
      check("t3_spacing", p_cyc[3] - p_cyc[2], 6);
      check("ready_drained", io_ready, 1'b1);

      // Push in the same cycle the last entry is popped.
      drive_wr(4'h3, 8'h11);
      drive_wr(4'h2, 8'h22);
      idle(20);
      check("t4_count", np, 14);
      check_pulse(12, 2'b01, 1'b1, 8'h11);
      check_pulse(13, 2'b01, 1'b0, 8'h22);
      check("t4_spacing", p_cyc[13] - p_cyc[12], 6);

      // Reset during the LOW phase aborts the pulse and drops the queue.
      drive_wr(4'h0, 8'h55);
      drive_wr(4'h1, 8'h66);
      drive_wr(4'h2, 8'h77);
      found = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (saa_wr_n === 1'b0) begin
            found = 1'b1;
            break;
         end
         @(posedge clk_sys); #1;
      end
      check("low_reached", found, 1'b1);
      rst_n = 1'b0;
      #1;
      check("abort_wr_n", saa_wr_n, 1'b1);
      check("abort_cs_n", saa_cs_n, 2'b11);
      idle(2);
      rst_n = 1'b1;
      check("post_rst_ready", io_ready, 1'b1);
      check("post_rst_ovf",   ovf,      1'b0);
      idle(20);
      check("t5_count", np, 14);
      check("post_rst_cs_n", saa_cs_n, 2'b11);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global time limit so the bench always ends on its own.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
